// File: rtl/nvram_sector_bridge_pkg.sv
// Shared types and constants for the NVRAM sector bridge.
package nvram_sector_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SERVE,
        CAPTURE,
        FLUSH,
        WAIT_REL
    } bridge_state_t;

    localparam int             SECTOR_BYTES = 512;
    localparam int             IDX_W        = $clog2(SECTOR_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(SECTOR_BYTES - 1);
    localparam logic [7:0]     FORMAT_BYTE  = 8'hFF;

endpackage

// File: rtl/nvram_sector_bridge_buf.sv
// One-sector 512x8 buffer: single write port, single registered read port.
module nvram_sector_buf
    import nvram_sector_bridge_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [7:0]       rd_data_p1
);

    logic [7:0] mem [SECTOR_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rd_data_p1 <= mem[raddr];
    end

endmodule

// File: rtl/nvram_sector_bridge.sv
// Sector bridge between the NVRAM sequencer / HPS SD port and cartridge SRAM.
// Optional statistics outputs are enabled with NVRAM_BRIDGE_STATS_EN.
module nvram_sector_bridge
    import nvram_sector_bridge_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int LBA_W  = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LBA_W-1:0]  ram_lba,
    input  logic [ADDR_W-1:0] ram_offset,
    input  logic              ram_format,
    input  logic              up_sd_rd,
    input  logic              up_sd_wr,
    output logic              up_sd_ack,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic [8:0]        sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    input  logic              sd_buff_wr,
    output logic [7:0]        sd_buff_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ready
`ifdef NVRAM_BRIDGE_STATS_EN
    ,
    output logic [15:0]       stat_loads,
    output logic [15:0]       stat_saves,
    output logic              stat_abort
`endif
);

    bridge_state_t     state;
    logic [IDX_W-1:0]  idx;
    logic [LBA_W-1:0]  lba_l;
    logic [ADDR_W-1:0] offset_l;
    logic              fmt_l;
    logic              up_wr_q, up_rd_q, sd_ack_q;
    logic              pend_wr, pend_rd;
    logic              abort_l;
    logic              rd_ok;
    logic [1:0]        rst_sync;
    logic              rst_n;

    logic [ADDR_W-1:0] base_addr, cur_addr;
    logic              wr_rise, rd_rise, new_sector, wr_req, rd_req, ack_fall;
    logic              serve_exit, flush_done, fill_abort;
    logic              buf_we;
    logic [IDX_W-1:0]  buf_waddr, buf_raddr;
    logic [7:0]        buf_wdata, rd_data_p1;

    // Asynchronous assert, synchronous release of the internal reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign base_addr  = offset_l + ADDR_W'({lba_l, {IDX_W{1'b0}}});
    assign cur_addr   = base_addr + ADDR_W'(idx);

    // A held request counts again once the sequencer has moved to another sector.
    assign wr_rise    = up_sd_wr & ~up_wr_q;
    assign rd_rise    = up_sd_rd & ~up_rd_q;
    assign new_sector = (ram_lba != lba_l) | (ram_format != fmt_l);
    assign wr_req     = up_sd_wr & (wr_rise | pend_wr | new_sector);
    assign rd_req     = up_sd_rd & (rd_rise | pend_rd | new_sector);
    assign ack_fall   = sd_ack_q & ~sd_ack;

    assign serve_exit = (state == SERVE) & ack_fall;
    assign flush_done = (state == FLUSH) & mem_wr & mem_ready & (idx == LAST_IDX);
    assign fill_abort = (state == FILL) & (~up_sd_wr | abort_l) & (~mem_rd | mem_ready);

    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = sd_buff_addr;
        buf_wdata = sd_buff_dout;
        if (state == FILL) begin
            buf_we    = mem_rd & mem_ready;
            buf_waddr = idx;
            buf_wdata = mem_dout;
        end else if (state == CAPTURE) begin
            buf_we    = sd_buff_wr;
        end
    end

    assign buf_raddr   = (state == FLUSH) ? idx : sd_buff_addr;
    assign sd_buff_din = (state != SERVE) ? 8'h00 :
                         (fmt_l ? FORMAT_BYTE : rd_data_p1);

    nvram_sector_buf u_buf (
        .clk        (clk),
        .we         (buf_we),
        .waddr      (buf_waddr),
        .wdata      (buf_wdata),
        .raddr      (buf_raddr),
        .rd_data_p1 (rd_data_p1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            lba_l     <= '0;
            offset_l  <= '0;
            fmt_l     <= 1'b0;
            up_wr_q   <= 1'b0;
            up_rd_q   <= 1'b0;
            sd_ack_q  <= 1'b0;
            pend_wr   <= 1'b0;
            pend_rd   <= 1'b0;
            abort_l   <= 1'b0;
            rd_ok     <= 1'b0;
            up_sd_ack <= 1'b0;
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
        end else begin
            up_wr_q  <= up_sd_wr;
            up_rd_q  <= up_sd_rd;
            sd_ack_q <= sd_ack;

            if (!up_sd_wr)                    pend_wr <= 1'b0;
            else if (wr_rise && state != IDLE) pend_wr <= 1'b1;
            if (!up_sd_rd)                                pend_rd <= 1'b0;
            else if (rd_rise && (state != IDLE || wr_req)) pend_rd <= 1'b1;

            case (state)
                IDLE: begin
                    idx     <= '0;
                    rd_ok   <= 1'b0;
                    abort_l <= 1'b0;
                    if (wr_req) begin
                        lba_l    <= ram_lba;
                        offset_l <= ram_offset;
                        fmt_l    <= ram_format;
                        pend_wr  <= 1'b0;
                        if (ram_format) begin
                            state <= SERVE;
                            sd_wr <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end else if (rd_req) begin
                        lba_l    <= ram_lba;
                        offset_l <= ram_offset;
                        fmt_l    <= ram_format;
                        pend_rd  <= 1'b0;
                        state    <= CAPTURE;
                        sd_rd    <= 1'b1;
                    end
                end
                FILL: begin
                    if (!up_sd_wr) abort_l <= 1'b1;
                    if (fill_abort) begin
                        mem_rd <= 1'b0;
                        state  <= IDLE;
                    end else if (mem_rd) begin
                        if (mem_ready) begin
                            mem_rd <= 1'b0;
                            if (idx == LAST_IDX) begin
                                idx   <= '0;
                                state <= SERVE;
                                sd_wr <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end else begin
                        mem_rd   <= 1'b1;
                        mem_addr <= cur_addr;
                    end
                end
                SERVE: begin
                    up_sd_ack <= sd_ack;
                    if (serve_exit) begin
                        sd_wr     <= 1'b0;
                        up_sd_ack <= 1'b0;
                        state     <= WAIT_REL;
                    end
                end
                CAPTURE: begin
                    if (sd_ack) up_sd_ack <= 1'b1;
                    if (ack_fall) begin
                        sd_rd <= 1'b0;
                        idx   <= '0;
                        rd_ok <= 1'b0;
                        state <= FLUSH;
                    end
                end
                // FLUSH: one idle clk per byte lets the registered buffer read settle.
                FLUSH: begin
                    if (mem_wr) begin
                        if (mem_ready) begin
                            mem_wr <= 1'b0;
                            rd_ok  <= 1'b0;
                            if (flush_done) begin
                                idx       <= '0;
                                up_sd_ack <= 1'b0;
                                state     <= WAIT_REL;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end else if (rd_ok) begin
                        mem_wr   <= 1'b1;
                        mem_din  <= rd_data_p1;
                        mem_addr <= cur_addr;
                        rd_ok    <= 1'b0;
                    end else begin
                        rd_ok <= 1'b1;
                    end
                end
                WAIT_REL: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

`ifdef NVRAM_BRIDGE_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads <= '0;
            stat_saves <= '0;
            stat_abort <= 1'b0;
        end else begin
            if (serve_exit) stat_saves <= sat_inc(stat_saves);
            if (flush_done) stat_loads <= sat_inc(stat_loads);
            if (fill_abort) stat_abort <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_nvram_sector_bridge.sv
// Scoreboard bench for nvram_sector_bridge with a 3-clk latency memory model.
module tb_nvram_sector_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] ram_lba;
    logic [24:0] ram_offset;
    logic        ram_format;
    logic        up_sd_rd, up_sd_wr, up_sd_ack;
    logic        sd_rd, sd_wr, sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout, sd_buff_din;
    logic        sd_buff_wr;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din, mem_dout;
    logic        mem_rd, mem_wr, mem_ready;
`ifdef NVRAM_BRIDGE_STATS_EN
    logic [15:0] stat_loads, stat_saves;
    logic        stat_abort;
`endif

    typedef struct packed {
        logic [24:0] a;
        logic [7:0]  d;
    } wr_t;

    logic [24:0] rd_q[$];
    wr_t         wr_q[$];
    int          reads_done  = 0;
    int          writes_done = 0;
    int          n_checks    = 0;
    int          n_fail      = 0;

    always #5 clk = ~clk;

    nvram_sector_bridge #(.ADDR_W(25), .LBA_W(13)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ram_lba      (ram_lba),
        .ram_offset   (ram_offset),
        .ram_format   (ram_format),
        .up_sd_rd     (up_sd_rd),
        .up_sd_wr     (up_sd_wr),
        .up_sd_ack    (up_sd_ack),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_ready    (mem_ready)
`ifdef NVRAM_BRIDGE_STATS_EN
        ,
        .stat_loads   (stat_loads),
        .stat_saves   (stat_saves),
        .stat_abort   (stat_abort)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Memory: returns addr[7:0] on reads, completes 3 clks after seeing a request.
    task automatic mem_model();
        int          lat   = 0;
        logic        busy  = 1'b0;
        logic        is_rd = 1'b0;
        logic [24:0] cur   = '0;
        wr_t         w;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                mem_ready = 1'b0;
                busy      = 1'b0;
                continue;
            end
            if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (busy) begin
                lat--;
                if (lat == 0) begin
                    busy      = 1'b0;
                    mem_ready = 1'b1;
                    if (is_rd) begin
                        mem_dout = cur[7:0];
                        reads_done++;
                    end else begin
                        writes_done++;
                    end
                end
            end else if (mem_rd || mem_wr) begin
                chk("mem_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
                busy  = 1'b1;
                lat   = 3;
                is_rd = mem_rd;
                cur   = mem_addr;
                if (mem_rd) begin
                    if (rd_q.size() == 0) chk("mem_rd_unexpected", {7'd0, mem_addr}, 32'hFFFF_FFFF);
                    else                  chk("fill_addr", {7'd0, mem_addr}, {7'd0, rd_q.pop_front()});
                end else begin
                    if (wr_q.size() == 0) begin
                        chk("mem_wr_unexpected", {7'd0, mem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        w = wr_q.pop_front();
                        chk("flush_addr", {7'd0, mem_addr}, {7'd0, w.a});
                        chk("flush_data", {24'd0, mem_din}, {24'd0, w.d});
                    end
                end
            end
        end
    endtask

    task automatic do_save(input logic [24:0] off, input logic [12:0] lba, input logic fmt);
        logic [24:0] base, t;
        logic [8:0]  probes[4] = '{9'd5, 9'd0, 9'h100, 9'h1FF};
        int          base_rd, cyc;
        base       = off + (25'(lba) << 9);
        ram_offset = off;
        ram_lba    = lba;
        ram_format = fmt;
        if (!fmt) for (int i = 0; i < 512; i++) rd_q.push_back(base + 25'(i));
        base_rd = reads_done;
        @(negedge clk);
        up_sd_wr = 1'b1;
        cyc = 0;
        while (sd_wr !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk("save_sd_wr", {31'd0, sd_wr}, 32'd1);
        if (fmt) chk("fmt_latency", {31'd0, cyc <= 2}, 32'd1);
        else     chk("fill_before_wr", reads_done - base_rd, 512);
        chk("fill_q_empty", rd_q.size(), 0);
        sd_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("save_up_ack", {31'd0, up_sd_ack}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            sd_buff_addr = probes[k];
            @(negedge clk);
            t = base + 25'(probes[k]);
            chk("save_din", {24'd0, sd_buff_din}, {24'd0, fmt ? 8'hFF : t[7:0]});
        end
        sd_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("save_sd_wr_drop", {31'd0, sd_wr}, 32'd0);
        chk("save_up_ack_drop", {31'd0, up_sd_ack}, 32'd0);
        up_sd_wr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_load(input logic [24:0] off, input logic [12:0] lba);
        logic [24:0] base;
        logic [7:0]  dv;
        int          base_wr, cyc;
        base       = off + (25'(lba) << 9);
        ram_offset = off;
        ram_lba    = lba;
        ram_format = 1'b0;
        base_wr    = writes_done;
        @(negedge clk);
        up_sd_rd = 1'b1;
        cyc = 0;
        while (sd_rd !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("load_sd_rd", {31'd0, sd_rd}, 32'd1);
        sd_ack = 1'b1;
        for (int i = 0; i < 512; i++) begin
            dv           = 8'hA0 + 8'(i);
            sd_buff_addr = 9'(i);
            sd_buff_dout = dv;
            sd_buff_wr   = 1'b1;
            wr_q.push_back('{a: base + 25'(i), d: dv});
            @(negedge clk);
        end
        sd_buff_wr = 1'b0;
        @(negedge clk);
        chk("load_up_ack", {31'd0, up_sd_ack}, 32'd1);
        sd_ack = 1'b0;
        repeat (20) @(negedge clk);
        chk("flush_ack_held", {31'd0, up_sd_ack}, 32'd1);
        cyc = 0;
        while (up_sd_ack !== 1'b0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk("load_ack_drop", {31'd0, up_sd_ack}, 32'd0);
        chk("flush_count_at_ack", writes_done - base_wr, 512);
        chk("flush_q_empty", wr_q.size(), 0);
        chk("load_sd_rd_drop", {31'd0, sd_rd}, 32'd0);
        up_sd_rd = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int   base_rd, base_wr, cyc;
        logic seen;
        reset_n      = 1'b0;
        ram_lba      = '0;
        ram_offset   = '0;
        ram_format   = 1'b0;
        up_sd_rd     = 1'b0;
        up_sd_wr     = 1'b0;
        sd_ack       = 1'b0;
        sd_buff_addr = '0;
        sd_buff_dout = '0;
        sd_buff_wr   = 1'b0;
        mem_dout     = '0;
        mem_ready    = 1'b0;
        fork
            mem_model();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_up_ack", {31'd0, up_sd_ack}, 32'd0);
        chk("rst_sd_wr", {31'd0, sd_wr}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_mem_addr", {7'd0, mem_addr}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        do_save(25'h0100000, 13'd2, 1'b0);
        do_load(25'h0000000, 13'd1);
        do_save(25'h0000000, 13'd3, 1'b1);
        do_save(25'h1FFFF00, 13'd0, 1'b0);

        // Abort a save part way through the prefetch.
        ram_offset = 25'h0040000;
        ram_lba    = 13'd5;
        ram_format = 1'b0;
        for (int i = 0; i < 512; i++) rd_q.push_back(25'h0040000 + 25'(5 << 9) + 25'(i));
        base_rd = reads_done;
        @(negedge clk);
        up_sd_wr = 1'b1;
        cyc = 0;
        while (reads_done - base_rd < 100 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reach100", {31'd0, (reads_done - base_rd) >= 100}, 32'd1);
        up_sd_wr = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (sd_wr) seen = 1'b1;
        end
        chk("abort_no_sd_wr", {31'd0, seen}, 32'd0);
        chk("abort_reads", {31'd0, (reads_done - base_rd) inside {100, 101}}, 32'd1);
        chk("abort_mem_idle", {31'd0, mem_rd}, 32'd0);
        rd_q.delete();
`ifdef NVRAM_BRIDGE_STATS_EN
        chk("stat_abort", {31'd0, stat_abort}, 32'd1);
        chk("stat_saves", {16'd0, stat_saves}, 32'd3);
        chk("stat_loads", {16'd0, stat_loads}, 32'd1);
`endif

        // Reset in the middle of a flush.
        ram_offset = 25'h0001000;
        ram_lba    = 13'd4;
        base_wr    = writes_done;
        @(negedge clk);
        up_sd_rd = 1'b1;
        cyc = 0;
        while (sd_rd !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        sd_ack = 1'b1;
        for (int i = 0; i < 512; i++) begin
            sd_buff_addr = 9'(i);
            sd_buff_dout = 8'(i * 3);
            sd_buff_wr   = 1'b1;
            wr_q.push_back('{a: 25'h0001000 + 25'(4 << 9) + 25'(i), d: 8'(i * 3)});
            @(negedge clk);
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        cyc = 0;
        while (writes_done - base_wr < 50 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_flush_reached", {31'd0, (writes_done - base_wr) >= 50}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_up_ack", {31'd0, up_sd_ack}, 32'd0);
        chk("arst_sd_rd", {31'd0, sd_rd}, 32'd0);
        chk("arst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("arst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("arst_mem_addr", {7'd0, mem_addr}, 32'd0);
        chk("arst_mem_din", {24'd0, mem_din}, 32'd0);
        chk("arst_sd_buff_din", {24'd0, sd_buff_din}, 32'd0);
        up_sd_rd = 1'b0;
        repeat (3) @(negedge clk);
        wr_q.delete();
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
`ifdef NVRAM_BRIDGE_STATS_EN
        chk("stat_rst_saves", {16'd0, stat_saves}, 32'd0);
        chk("stat_rst_abort", {31'd0, stat_abort}, 32'd0);
`endif
        do_save(25'h0002000, 13'd7, 1'b0);
`ifdef NVRAM_BRIDGE_STATS_EN
        chk("stat_saves_after", {16'd0, stat_saves}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
